uart_calc_core: RTL and testbench



---
 rtl/uart_calc_pkg.sv | 73 +++++++
 rtl/uart_calc_core_bin2bcd.sv | 59 +++++
 rtl/uart_calc_core.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_calc_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_calc_pkg.sv
// Shared types and constants for the UART ASCII calculator.
// Holds FSM/operator/transmit-phase enums, ASCII codes and size defaults.
package uart_calc_pkg;

  localparam int DEF_MAX_DIG = 4;
  localparam int DEF_RES_W   = 27;

  typedef enum logic [2:0] {
    OPA,
    OPB,
    FLUSH,
    CALC,
    CONV,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_e;

  typedef enum logic [2:0] {
    PH_SIGN,
    PH_DIG,
    PH_E,
    PH_CR,
    PH_LF,
    PH_END
  } send_ph_e;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_E     = 8'h45;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] b);
    return (b == CH_PLUS) || (b == CH_MINUS) || (b == CH_STAR);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_EQ) || (b == CH_CR);
  endfunction

  function automatic op_e op_of(input logic [7:0] b);
    case (b)
      CH_PLUS:  return OP_ADD;
      CH_MINUS: return OP_SUB;
      default:  return OP_MUL;
    endcase
  endfunction

  // Index of the most significant non-zero BCD digit; 0 for an all-zero value.
  function automatic logic [2:0] lead_idx(input logic [31:0] d);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d[4*i +: 4] != 4'd0) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_calc_core_bin2bcd.sv
// Iterative double-dabble: RES_W shifts, the first one taken on the start edge,
// so done pulses exactly RES_W cycles after start.
module bin2bcd
  import uart_calc_pkg::*;
#(
  parameter int RES_W = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic [31:0]      bcd,
  output logic             done
);

  localparam int CW = $clog2(RES_W + 1);

  logic [RES_W-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [31:0]      bcd_nxt;

  always_comb begin
    bcd_nxt    = '0;
    bcd_nxt[0] = sh[RES_W-1];
    for (int i = 0; i < 7; i++) begin
      bcd_nxt[4*i+1 +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // Top digit's carry-out is dropped: results never exceed eight digits.
    bcd_nxt[31:29] = (bcd[31:28] >= 4'd5) ? 3'(bcd[30:28] + 3'd3) : bcd[30:28];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd    <= '0;
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd    <= {31'd0, bin[RES_W-1]};
        sh     <= bin << 1;
        cnt    <= CW'(RES_W - 1);
        active <= 1'b1;
      end else if (active) begin
        bcd <= bcd_nxt;
        sh  <= sh << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_calc_core.sv
// ASCII calculator between UART rx and tx: parses "<A><op><B>=" and streams
// the signed decimal result (or "E") followed by CR LF.
//
//   state | meaning
//   OPA   | accumulating operand A, waiting for operator
//   OPB   | accumulating operand B, waiting for '=' or CR
//   FLUSH | syntax error seen, discarding bytes until '=' or CR
//   CALC  | one-cycle arithmetic into the magnitude register
//   CONV  | waiting for binary-to-BCD conversion
//   SEND  | streaming sign, digits / "E", CR, LF to the transmitter
module uart_calc_core
  import uart_calc_pkg::*;
#(
  parameter int MAX_DIG = DEF_MAX_DIG,
  parameter int RES_W   = DEF_RES_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       uout_valid,
  output logic       busy
);

  localparam int OPW = $clog2(10 ** MAX_DIG);
  localparam int CNW = $clog2(MAX_DIG + 1);

  state_e           state;
  op_e              op_r;
  logic [OPW-1:0]   a_r, b_r;
  logic [CNW-1:0]   a_cnt, b_cnt;
  logic             neg_r, err_r, sent_r;
  logic [RES_W-1:0] mag_r;
  logic             bcd_start, bcd_done;
  logic [31:0]      bcd;
  send_ph_e         phase_r;
  logic [2:0]       idx_r;
  logic [31:0]      dig_r;

  logic             launch, fire;
  send_ph_e         cur_ph, nxt_ph;
  logic [2:0]       cur_idx, nxt_idx;
  logic [31:0]      cur_dig;
  logic [7:0]       tx_byte;

  bin2bcd #(.RES_W(RES_W)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (mag_r),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // Emission path is shared by the entry cycles (FLUSH terminator, CONV done)
  // and SEND, so the first byte can go out without an extra cycle.
  always_comb begin
    case (state)
      FLUSH:   launch = rx_valid && is_term(rx_data);
      CONV:    launch = bcd_done;
      SEND:    launch = 1'b1;
      default: launch = 1'b0;
    endcase

    if (state == SEND) begin
      cur_ph  = phase_r;
      cur_idx = idx_r;
      cur_dig = dig_r;
    end else begin
      cur_ph  = err_r ? PH_E : (neg_r ? PH_SIGN : PH_DIG);
      cur_idx = lead_idx(bcd);
      cur_dig = bcd;
    end

    fire    = launch && tx_ready && !sent_r && (cur_ph != PH_END);
    nxt_ph  = cur_ph;
    nxt_idx = cur_idx;
    tx_byte = CH_LF;
    case (cur_ph)
      PH_SIGN: begin
        tx_byte = CH_MINUS;
        nxt_ph  = PH_DIG;
      end
      PH_DIG: begin
        tx_byte = CH_0 | {4'h0, cur_dig[{cur_idx, 2'b00} +: 4]};
        if (cur_idx == 3'd0) nxt_ph = PH_CR;
        else                 nxt_idx = cur_idx - 3'd1;
      end
      PH_E: begin
        tx_byte = CH_E;
        nxt_ph  = PH_CR;
      end
      PH_CR: begin
        tx_byte = CH_CR;
        nxt_ph  = PH_LF;
      end
      PH_LF: begin
        tx_byte = CH_LF;
        nxt_ph  = PH_END;
      end
      default: ;
    endcase
    if (!fire) begin
      nxt_ph  = cur_ph;
      nxt_idx = cur_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OPA;
      op_r       <= OP_ADD;
      a_r        <= '0;
      b_r        <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      neg_r      <= 1'b0;
      err_r      <= 1'b0;
      sent_r     <= 1'b0;
      mag_r      <= '0;
      bcd_start  <= 1'b0;
      phase_r    <= PH_SIGN;
      idx_r      <= '0;
      dig_r      <= '0;
      tx_data    <= 8'h00;
      uout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      uout_valid <= fire;
      bcd_start  <= 1'b0;
      // sent holds off a second strobe until the transmitter has gone busy
      if (fire) begin
        tx_data <= tx_byte;
        sent_r  <= 1'b1;
      end else if (!tx_ready) begin
        sent_r <= 1'b0;
      end

      case (state)
        OPA: if (rx_valid) begin
          if (is_digit(rx_data)) begin
            if (a_cnt == CNW'(MAX_DIG)) begin
              state <= FLUSH;
              err_r <= 1'b1;
            end else begin
              a_r   <= a_r * OPW'(10) + OPW'(rx_data[3:0]);
              a_cnt <= a_cnt + CNW'(1);
            end
          end else if (is_op(rx_data) && (a_cnt != '0)) begin
            op_r  <= op_of(rx_data);
            state <= OPB;
          end else if (rx_data != CH_SP) begin
            state <= FLUSH;
            err_r <= 1'b1;
          end
        end

        OPB: if (rx_valid) begin
          if (is_digit(rx_data)) begin
            if (b_cnt == CNW'(MAX_DIG)) begin
              state <= FLUSH;
              err_r <= 1'b1;
            end else begin
              b_r   <= b_r * OPW'(10) + OPW'(rx_data[3:0]);
              b_cnt <= b_cnt + CNW'(1);
            end
          end else if (is_term(rx_data) && (b_cnt != '0)) begin
            state <= CALC;
            busy  <= 1'b1;
          end else if (rx_data != CH_SP) begin
            state <= FLUSH;
            err_r <= 1'b1;
          end
        end

        FLUSH: if (launch) begin
          state   <= SEND;
          busy    <= 1'b1;
          phase_r <= nxt_ph;
          idx_r   <= nxt_idx;
          dig_r   <= cur_dig;
        end

        CALC: begin
          case (op_r)
            OP_ADD:  mag_r <= RES_W'(a_r) + RES_W'(b_r);
            OP_SUB:  mag_r <= (a_r >= b_r) ? RES_W'(a_r - b_r) : RES_W'(b_r - a_r);
            default: mag_r <= RES_W'(a_r) * RES_W'(b_r);
          endcase
          neg_r     <= (op_r == OP_SUB) && (a_r < b_r);
          bcd_start <= 1'b1;
          state     <= CONV;
        end

        CONV: if (launch) begin
          state   <= SEND;
          phase_r <= nxt_ph;
          idx_r   <= nxt_idx;
          dig_r   <= cur_dig;
        end

        SEND: begin
          if (phase_r == PH_END) begin
            state <= OPA;
            busy  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
            op_r  <= OP_ADD;
            neg_r <= 1'b0;
            err_r <= 1'b0;
          end else begin
            phase_r <= nxt_ph;
            idx_r   <= nxt_idx;
          end
        end

        default: state <= OPA;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_calc_core.sv
// Scoreboard bench for uart_calc_core: directed expressions push expected
// bytes, a monitor pops and compares on every uout_valid strobe.
module tb_uart_calc_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       uout_valid;
  logic       busy;

  uart_calc_core dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .uout_valid (uout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_strobes = 0;
  int   fall_dly = 1;
  int   busy_len = 1;
  int   fall_cnt = 0;
  int   low_cnt = 0;
  bit   saw_low = 0;
  bit   seen_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: goes busy fall_dly cycles after a strobe, for busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) tx_ready = 1'b1;
      end
      if (fall_cnt > 0) begin
        fall_cnt--;
        if (fall_cnt == 0) begin
          tx_ready = 1'b0;
          low_cnt  = busy_len;
        end
      end
      if (uout_valid) fall_cnt = fall_dly;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen_strobe = 0;
        saw_low     = 0;
      end else begin
        if (uout_valid) begin
          n_strobes++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got byte 0x%02h at cycle %0d, expected no strobe", tx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.b) begin
              n_fail++;
              $display("FAIL tx_byte: got 0x%02h, expected 0x%02h (cycle %0d)", tx_data, e.b, cyc);
            end
            if (e.at >= 0) begin
              n_checks++;
              if (cyc != e.at) begin
                n_fail++;
                $display("FAIL first_strobe_cycle: got %0d, expected %0d", cyc, e.at);
              end
            end
          end
          if (seen_strobe) begin
            n_checks++;
            if (!saw_low) begin
              n_fail++;
              $display("FAIL one_strobe_per_busy: got second strobe at cycle %0d, expected tx_ready low first", cyc);
            end
          end
          seen_strobe = 1;
          saw_low     = 0;
        end
        if (!tx_ready) saw_low = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Last character of expr is the terminator; resp is pushed as it is presented.
  task automatic run_expr(input string expr, input string resp, input int lat);
    exp_t x;
    for (int i = 0; i < expr.len(); i++) begin
      if (i == expr.len() - 1) begin
        @(posedge clk);
        #1;
        rx_data  = expr[i];
        rx_valid = 1'b1;
        for (int j = 0; j < resp.len(); j++) begin
          x.b  = resp[j];
          x.at = (j == 0 && lat >= 0) ? cyc + lat : -1;
          exp_q.push_back(x);
        end
        @(negedge clk);
        chk({"busy_before_term ", expr}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk({"busy_after_term ", expr}, {31'd0, busy}, 32'd1);
      end else begin
        send_byte(expr[i]);
      end
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still pending after timeout, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_data", {24'd0, tx_data}, 32'h00);
    chk("reset_uout_valid", {31'd0, uout_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_expr("12+34=", "46\015\012", 30);
    drain("add");
    run_expr("5-123\015", "-118\015\012", -1);
    drain("sub_neg");
    run_expr("7-7=", "0\015\012", -1);
    drain("sub_zero");
    run_expr("9999*9999=", "99980001\015\012", -1);
    drain("mul_max");
    run_expr("+3=", "E\015\012", 1);
    drain("err_op_first");
    run_expr("12345+1=", "E\015\012", 1);
    drain("err_digits");
    run_expr("1a+2=", "E\015\012", 1);
    drain("err_char");
    run_expr(" 8 + 4 =", "12\015\012", 30);
    drain("spaces");

    fall_dly = 3;
    busy_len = 10;
    run_expr("2*3=", "6\015\012", -1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_at_inject", {31'd0, busy}, 32'd1);
      send_byte((i == 1) ? 8'h2B : ((i == 3) ? 8'h3D : 8'h39));
    end
    drain("slow_tx");
    run_expr("1+1=", "2\015\012", -1);
    drain("after_inject");

    fall_dly = 1;
    busy_len = 1;
    run_expr("99*99=", "9", -1);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_send_first_byte_seen", {31'd0, (exp_q.size() == 0)}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_mid_uout_valid", {31'd0, uout_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    snap = n_strobes;
    repeat (80) @(negedge clk);
    chk("no_strobes_after_rst", n_strobes - snap, 32'd0);
    run_expr("3*3=", "9\015\012", -1);
    drain("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
